// File: rtl/icache_loader.sv
// Packs pairs of 32-bit host beats into 54-bit instructions, writes them into the icache from address 0,
// and runs the start/finish handshake. Define ICACHE_AUTO_FINISH_EN to append a finish instruction after the program.
module icache_loader #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 54,
    parameter int BUS_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [BUS_W-1:0]   host_data,
    input  logic               host_last,
    input  logic               host_start,
    input  logic               host_abort,
    input  logic               ctrl_finish,
    output logic               icache_wr_en,
    output logic [ADDR_W-1:0]  icache_wr_addr,
    output logic [INSTR_W-1:0] icache_wr_data,
    output logic               global_en,
    output logic [ADDR_W:0]    prog_len,
    output logic               done_pulse,
    output logic               err_malformed,
    output logic               err_overflow
);

`ifdef ICACHE_AUTO_FINISH_EN
    typedef enum logic [2:0] {IDLE, LD_HI, FIN, LOADED, RUN} state_t;
`else
    typedef enum logic [2:0] {IDLE, LD_HI, LOADED, RUN} state_t;
`endif

    localparam int                 HI_W         = INSTR_W - BUS_W;
    localparam logic [ADDR_W-1:0]  PTR_MAX      = '1;
    localparam logic [ADDR_W:0]    ONE_LEN      = (ADDR_W+1)'(1);
    localparam logic [INSTR_W-1:0] FINISH_INSTR = {1'b1, {(INSTR_W-1){1'b0}}};

    state_t             state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [BUS_W-1:0]   lo_data;
    logic               accept;

    assign accept = host_valid && host_ready;

    // The low half only matters once the matching high beat arrives, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            lo_data <= host_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            host_ready     <= 1'b0;
            icache_wr_en   <= 1'b0;
            icache_wr_addr <= '0;
            icache_wr_data <= '0;
            global_en      <= 1'b0;
            prog_len       <= '0;
            done_pulse     <= 1'b0;
            err_malformed  <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            icache_wr_en <= 1'b0;
            done_pulse   <= 1'b0;
            if (host_abort) begin
                // Abort overrides start, finish and any beat accepted this cycle.
                state         <= IDLE;
                wr_ptr        <= '0;
                err_malformed <= 1'b0;
                err_overflow  <= 1'b0;
                global_en     <= 1'b0;
                host_ready    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && host_last) begin
                            err_malformed <= 1'b1;
                            host_ready    <= 1'b0;
                        end else if (accept) begin
                            state <= LD_HI;
                        end else begin
                            host_ready <= !(err_malformed || err_overflow);
                        end
                    end
                    LD_HI: begin
                        if (accept) begin
                            icache_wr_en   <= 1'b1;
                            icache_wr_addr <= wr_ptr;
                            icache_wr_data <= {host_data[HI_W-1:0], lo_data};
                            prog_len       <= {1'b0, wr_ptr} + ONE_LEN;
                            if (wr_ptr != PTR_MAX) begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                            if (host_last) begin
                                host_ready <= 1'b0;
`ifdef ICACHE_AUTO_FINISH_EN
                                state      <= FIN;
`else
                                state      <= LOADED;
`endif
                            end else begin
                                state <= IDLE;
                                // Pointer saturates at the top; any further program is an overflow.
                                if (wr_ptr == PTR_MAX) begin
                                    err_overflow <= 1'b1;
                                    host_ready   <= 1'b0;
                                end
                            end
                        end
                    end
`ifdef ICACHE_AUTO_FINISH_EN
                    FIN: begin
                        // prog_len MSB set means the program itself used every slot.
                        if (prog_len[ADDR_W]) begin
                            err_overflow <= 1'b1;
                        end else begin
                            icache_wr_en   <= 1'b1;
                            icache_wr_addr <= wr_ptr;
                            icache_wr_data <= FINISH_INSTR;
                            prog_len       <= {1'b0, wr_ptr} + ONE_LEN;
                            if (wr_ptr != PTR_MAX) begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end
                        state <= LOADED;
                    end
`endif
                    LOADED: begin
                        if (host_start && !err_malformed && !err_overflow) begin
                            state     <= RUN;
                            global_en <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (ctrl_finish) begin
                            state         <= IDLE;
                            global_en     <= 1'b0;
                            done_pulse    <= 1'b1;
                            wr_ptr        <= '0;
                            err_malformed <= 1'b0;
                            err_overflow  <= 1'b0;
                            host_ready    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
